// File: rtl/div_seq.sv
// RV32M divide sequencer: restoring division, one quotient bit per cycle,
// borrowing the execute-stage ALU for every subtract and negate.
module div_seq #(
   parameter int         WIDTH    = 32,
   parameter logic [3:0] OP_SUB   = 4'd12,
   parameter logic [3:0] OP_PASSB = 4'd13,
   parameter logic [3:0] OP_ADD   = 4'd0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       funct,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] alu_out
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ABS_A = 3'd1;
   localparam logic [2:0] S_ABS_B = 3'd2;
   localparam logic [2:0] S_ITER  = 3'd3;
   localparam logic [2:0] S_FIX   = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   localparam logic [4:0]       LAST_BIT = 5'(WIDTH - 1);
   localparam logic [WIDTH-1:0] INT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

   logic [2:0]       state;
   logic [4:0]       cnt;
   logic             rem_q, sgn, neg_q, neg_r;
   logic [WIDTH-1:0] a_q, d_q, d_abs, r_q, q_q;
   logic [WIDTH:0]   rs;
   logic             ge, neg, div0, ovf;
   logic [WIDTH-1:0] sel;

   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);

   // Shifted partial remainder; its msb can only be set by the bit shifted out
   // of r_q, which then guarantees the subtract fits.
   assign rs  = {r_q, q_q[WIDTH-1]};
   assign ge  = rs[WIDTH] | (rs[WIDTH-1:0] >= d_abs);
   assign sel = rem_q ? r_q : q_q;
   assign neg = rem_q ? neg_r : neg_q;

   assign div0 = (divisor == '0);
   assign ovf  = ~funct[0] & (dividend == INT_MIN) & (divisor == '1);

   always_comb begin
      alu_a  = '0;
      alu_b  = '0;
      alu_op = OP_ADD;
      case (state)
         S_ABS_A: begin
            alu_b  = a_q;
            alu_op = (sgn & a_q[WIDTH-1]) ? OP_SUB : OP_PASSB;
         end
         S_ABS_B: begin
            alu_b  = d_q;
            alu_op = (sgn & d_q[WIDTH-1]) ? OP_SUB : OP_PASSB;
         end
         S_ITER: begin
            alu_a  = rs[WIDTH-1:0];
            alu_b  = d_abs;
            alu_op = OP_SUB;
         end
         S_FIX: begin
            alu_b  = sel;
            alu_op = neg ? OP_SUB : OP_PASSB;
         end
         default: ;
      endcase
   end

   // Control and architecturally visible result
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         cnt    <= '0;
         rem_q  <= 1'b0;
         sgn    <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         result <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  rem_q <= funct[1];
                  sgn   <= ~funct[0];
                  if (div0) begin
                     result <= funct[1] ? dividend : '1;
                     state  <= S_DONE;
                  end else if (ovf) begin
                     result <= funct[1] ? '0 : INT_MIN;
                     state  <= S_DONE;
                  end else begin
                     state <= S_ABS_A;
                  end
               end
            end
            S_ABS_A: begin
               neg_q <= sgn & (a_q[WIDTH-1] ^ d_q[WIDTH-1]);
               neg_r <= sgn & a_q[WIDTH-1];
               state <= S_ABS_B;
            end
            S_ABS_B: begin
               cnt   <= '0;
               state <= S_ITER;
            end
            S_ITER: begin
               cnt <= cnt + 5'd1;
               if (cnt == LAST_BIT) state <= S_FIX;
            end
            S_FIX: begin
               result <= alu_out;
               state  <= S_DONE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Datapath registers carry no reset; control qualifies every use
   always_ff @(posedge clk) begin
      case (state)
         S_IDLE: begin
            if (start) begin
               a_q <= dividend;
               d_q <= divisor;
            end
         end
         S_ABS_A: q_q <= alu_out;
         S_ABS_B: begin
            d_abs <= alu_out;
            r_q   <= '0;
         end
         S_ITER: begin
            r_q <= ge ? alu_out : rs[WIDTH-1:0];
            q_q <= {q_q[WIDTH-2:0], ge};
         end
         default: ;
      endcase
   end

endmodule
